// File: rtl/pc_fetch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer_pkg
// Shared definitions for the LEGv8 fetch sequencer and its next-PC mux:
//   seq_state_t  : sequencer state encoding (IDLE / RUN / HALT)
//   INSTR_BYTES  : byte distance between sequential instructions
//   WORD_SHIFT   : shift that turns a word offset into a byte offset
//   is_misaligned: true when a byte address is not on a 4-byte boundary
// ---------------------------------------------------------------------------
package pc_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seq_state_t;

    localparam int INSTR_BYTES = 4;
    localparam int WORD_SHIFT  = 2;

    // An instruction address must have its two low bits clear.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_pc_next_mux.sv
// ---------------------------------------------------------------------------
// pc_next_mux
// Combinational next-PC selection, shared with the pipelined fetch stage.
// Ports:
//   pc           in  ADDR_W  current program counter
//   branch_taken in  1       select the branch target
//   offset       in  ADDR_W  signed word offset (already sign-extended)
//   adder_out    out ADDR_W  pc + 4
//   next_pc      out ADDR_W  branch ? pc + (offset << 2) : pc + 4
// All arithmetic wraps modulo 2^ADDR_W; the shift drops the top two bits.
// ---------------------------------------------------------------------------
module pc_next_mux
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] offset,
    output logic [ADDR_W-1:0] adder_out,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] seq_pc_s;
    logic [ADDR_W-1:0] branch_pc_s;

    assign seq_pc_s    = pc + ADDR_W'(INSTR_BYTES);
    assign branch_pc_s = pc + (offset << WORD_SHIFT);
    assign adder_out   = seq_pc_s;

    // Pick the branch target or the sequential successor.
    always_comb begin
        next_pc = seq_pc_s;
        if (branch_taken) begin
            next_pc = branch_pc_s;
        end else begin
            next_pc = seq_pc_s;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
// On-chip program-counter sequencer for the single-cycle LEGv8 datapath.
// After start it issues MAX_INSTR instructions (sequential or branch
// successors), honours stall, and then halts until reset.
// Optional feature macro: PC_ALIGN_CHECK_EN (adds align_fault and halts on a
// misaligned next PC).
// Ports:
//   clock         in  1       system clock, rising edge
//   reset         in  1       asynchronous active-high reset
//   start         in  1       begin fetching at RESET_PC (IDLE only)
//   stall         in  1       hold PC and count this cycle
//   branch_taken  in  1       take branch target on the retiring edge
//   branch_offset in  ADDR_W  signed word offset
//   pc_out        out ADDR_W  registered current PC
//   adder_out     out ADDR_W  combinational pc_out + 4
//   pc_valid      out 1       pc_out holds an instruction to execute
//   inst_count    out CNT_W   instructions retired since start
//   halted        out 1       sticky halt indication
//   align_fault   out 1       (PC_ALIGN_CHECK_EN only) misaligned next PC
// ---------------------------------------------------------------------------
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
    parameter int                MAX_INSTR = 8,
    parameter int                CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_offset,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] adder_out,
    output logic              pc_valid,
    output logic [CNT_W-1:0]  inst_count,
`ifdef PC_ALIGN_CHECK_EN
    output logic              align_fault,
`endif
    output logic              halted
);

    // The budget must be at least one and representable in inst_count.
    if ((MAX_INSTR < 1) ||
        (longint'(MAX_INSTR) > ((longint'(1) <<< CNT_W) - longint'(1)))) begin : g_bad_budget
        $error("pc_fetch_sequencer: MAX_INSTR must be >= 1 and fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_BUDGET = CNT_W'(MAX_INSTR);

    seq_state_t        state_r;
    logic [ADDR_W-1:0] pc_r;
    logic              valid_r;
    logic [CNT_W-1:0]  count_r;
    logic              halted_r;
    logic [ADDR_W-1:0] next_pc_s;
    logic [CNT_W-1:0]  count_inc_s;
    logic              budget_hit_s;
    logic              misalign_s;
`ifdef PC_ALIGN_CHECK_EN
    logic              align_fault_r;
`endif

    pc_next_mux #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_mux (
        .pc           (pc_r),
        .branch_taken (branch_taken),
        .offset       (branch_offset),
        .adder_out    (adder_out),
        .next_pc      (next_pc_s)
    );

    // Saturating increment; saturation is unreachable with a legal budget.
    assign count_inc_s  = (count_r == CNT_SAT) ? count_r : (count_r + {{(CNT_W-1){1'b0}}, 1'b1});
    assign budget_hit_s = (count_inc_s == CNT_BUDGET);

`ifdef PC_ALIGN_CHECK_EN
    assign misalign_s   = is_misaligned(next_pc_s[1:0]);
`else
    assign misalign_s   = 1'b0;
`endif

    // Sequencer FSM: owns state, PC, retire count and status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            pc_r     <= RESET_PC;
            valid_r  <= 1'b0;
            count_r  <= {CNT_W{1'b0}};
            halted_r <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            align_fault_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= RUN;
                        pc_r    <= RESET_PC;
                        valid_r <= 1'b1;
                        count_r <= {CNT_W{1'b0}};
                    end else begin
                        valid_r <= 1'b0;
                    end
                end
                RUN: begin
                    // A stalled edge retires nothing, so it can never halt.
                    if (!stall) begin
                        pc_r    <= next_pc_s;
                        count_r <= count_inc_s;
                        if (budget_hit_s || misalign_s) begin
                            state_r  <= HALT;
                            valid_r  <= 1'b0;
                            halted_r <= 1'b1;
                        end else begin
                            valid_r  <= 1'b1;
                        end
`ifdef PC_ALIGN_CHECK_EN
                        if (misalign_s) begin
                            align_fault_r <= 1'b1;
                        end else begin
                            align_fault_r <= align_fault_r;
                        end
`endif
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                HALT: begin
                    // Sticky until reset; start is ignored.
                    valid_r  <= 1'b0;
                    halted_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out     = pc_r;
    assign pc_valid   = valid_r;
    assign inst_count = count_r;
    assign halted     = halted_r;
`ifdef PC_ALIGN_CHECK_EN
    assign align_fault = align_fault_r;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_sequencer
// Directed bench for pc_fetch_sequencer with hand-computed expectations.
// dut_main : RESET_PC=0, MAX_INSTR=8 (straight run, branches, stall, resets)
// dut_wrap : RESET_PC=all-ones-minus-3, MAX_INSTR=2 (PC wrap)
// dut_mis  : RESET_PC=2 (only with PC_ALIGN_CHECK_EN, alignment fault)
// ---------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

    localparam int ADDR_W = 64;
    localparam int CNT_W  = 16;

    logic              clock;
    logic              reset;
    logic              start;
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_offset;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] adder_out;
    logic              pc_valid;
    logic [CNT_W-1:0]  inst_count;
    logic              halted;

    logic              start_wrap;
    logic              zero_bit;
    logic [ADDR_W-1:0] zero_off;
    logic [ADDR_W-1:0] pc_wrap;
    logic [ADDR_W-1:0] adder_wrap;
    logic              valid_wrap;
    logic [CNT_W-1:0]  count_wrap;
    logic              halted_wrap;

`ifdef PC_ALIGN_CHECK_EN
    logic              align_fault;
    logic              align_fault_wrap;
    logic              start_mis;
    logic [ADDR_W-1:0] pc_mis;
    logic [ADDR_W-1:0] adder_mis;
    logic              valid_mis;
    logic [CNT_W-1:0]  count_mis;
    logic              halted_mis;
    logic              align_fault_mis;
`endif

    int n_checks;
    int n_errors;

    pc_fetch_sequencer #(
        .ADDR_W    (ADDR_W),
        .RESET_PC  (64'h0),
        .MAX_INSTR (8),
        .CNT_W     (CNT_W)
    ) dut_main (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .pc_out        (pc_out),
        .adder_out     (adder_out),
        .pc_valid      (pc_valid),
        .inst_count    (inst_count),
`ifdef PC_ALIGN_CHECK_EN
        .align_fault   (align_fault),
`endif
        .halted        (halted)
    );

    pc_fetch_sequencer #(
        .ADDR_W    (ADDR_W),
        .RESET_PC  (64'hFFFF_FFFF_FFFF_FFFC),
        .MAX_INSTR (2),
        .CNT_W     (CNT_W)
    ) dut_wrap (
        .clock         (clock),
        .reset         (reset),
        .start         (start_wrap),
        .stall         (zero_bit),
        .branch_taken  (zero_bit),
        .branch_offset (zero_off),
        .pc_out        (pc_wrap),
        .adder_out     (adder_wrap),
        .pc_valid      (valid_wrap),
        .inst_count    (count_wrap),
`ifdef PC_ALIGN_CHECK_EN
        .align_fault   (align_fault_wrap),
`endif
        .halted        (halted_wrap)
    );

`ifdef PC_ALIGN_CHECK_EN
    pc_fetch_sequencer #(
        .ADDR_W    (ADDR_W),
        .RESET_PC  (64'h2),
        .MAX_INSTR (8),
        .CNT_W     (CNT_W)
    ) dut_mis (
        .clock         (clock),
        .reset         (reset),
        .start         (start_mis),
        .stall         (zero_bit),
        .branch_taken  (zero_bit),
        .branch_offset (zero_off),
        .pc_out        (pc_mis),
        .adder_out     (adder_mis),
        .pc_valid      (valid_mis),
        .inst_count    (count_mis),
        .align_fault   (align_fault_mis),
        .halted        (halted_mis)
    );
`endif

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        start         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 64'h0;
        start_wrap    = 1'b0;
        zero_bit      = 1'b0;
        zero_off      = 64'h0;
`ifdef PC_ALIGN_CHECK_EN
        start_mis     = 1'b0;
`endif

        // Reset values
        tick();
        check_val("rst_pc",      pc_out,     64'h0);
        check_val("rst_valid",   pc_valid,   64'h0);
        check_val("rst_count",   inst_count, 64'h0);
        check_val("rst_halted",  halted,     64'h0);
        check_val("rst_pc_wrap", pc_wrap,    64'hFFFF_FFFF_FFFF_FFFC);

        reset = 1'b0;
        tick();
        check_val("idle_valid", pc_valid, 64'h0);

        // Straight-line run: 0,4,...,28 then halt at 32 after 8 retires
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("start_pc",    pc_out,    64'h0);
        check_val("start_valid", pc_valid,  64'h1);
        check_val("start_adder", adder_out, 64'h4);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check_val("seq_pc",     pc_out,     64'(4 * i));
            check_val("seq_count",  inst_count, 64'(i));
            check_val("seq_halted", halted,     64'h0);
        end
        tick();
        check_val("halt_pc",     pc_out,     64'd32);
        check_val("halt_count",  inst_count, 64'd8);
        check_val("halt_halted", halted,     64'h1);
        check_val("halt_valid",  pc_valid,   64'h0);

        // start is ignored while halted
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        check_val("sticky_pc",     pc_out,     64'd32);
        check_val("sticky_halted", halted,     64'h1);
        check_val("sticky_valid",  pc_valid,   64'h0);
        check_val("sticky_count",  inst_count, 64'd8);

        // PC wrap past all-ones
        start_wrap = 1'b1;
        tick();
        start_wrap = 1'b0;
        check_val("wrap_pc0",    pc_wrap,     64'hFFFF_FFFF_FFFF_FFFC);
        check_val("wrap_valid0", valid_wrap,  64'h1);
        tick();
        check_val("wrap_pc1",     pc_wrap,     64'h0);
        check_val("wrap_count1",  count_wrap,  64'h1);
        check_val("wrap_halted1", halted_wrap, 64'h0);
        tick();
        check_val("wrap_pc2",     pc_wrap,     64'h4);
        check_val("wrap_halted2", halted_wrap, 64'h1);

        // Asynchronous reset clears a halted sequencer between edges
        #2;
        reset = 1'b1;
        #1;
        check_val("async_rst_pc",     pc_out,     64'h0);
        check_val("async_rst_halted", halted,     64'h0);
        check_val("async_rst_count",  inst_count, 64'h0);
        reset = 1'b0;

        // Branches: offset 0 at pc=4, +1, +3, -2
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("b_start_pc", pc_out, 64'h0);
        tick();
        check_val("b_pc4", pc_out, 64'h4);
        branch_taken  = 1'b1;
        branch_offset = 64'h0;
        tick();
        check_val("b_off0_pc",    pc_out,     64'h4);
        check_val("b_off0_count", inst_count, 64'd2);
        branch_offset = 64'h1;
        tick();
        check_val("b_off1_pc", pc_out, 64'h8);
        branch_offset = 64'h3;
        tick();
        check_val("b_plus3_pc", pc_out, 64'd20);
        branch_offset = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        check_val("b_minus2_pc",    pc_out,     64'd12);
        check_val("b_minus2_count", inst_count, 64'd5);

        // Stall with a pending branch holds PC and count; start ignored in RUN
        stall         = 1'b1;
        branch_offset = 64'h5;
        start         = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("stall_pc",    pc_out,     64'd12);
            check_val("stall_count", inst_count, 64'd5);
            check_val("stall_valid", pc_valid,   64'h1);
        end
        stall        = 1'b0;
        branch_taken = 1'b0;
        start        = 1'b0;
        tick();
        check_val("unstall_pc",    pc_out,     64'd16);
        check_val("unstall_count", inst_count, 64'd6);

        // Mid-run reset at pc=16 takes effect without a clock edge
        #2;
        reset = 1'b1;
        #1;
        check_val("mid_rst_pc",     pc_out,     64'h0);
        check_val("mid_rst_valid",  pc_valid,   64'h0);
        check_val("mid_rst_count",  inst_count, 64'h0);
        check_val("mid_rst_halted", halted,     64'h0);
        reset = 1'b0;
        tick();
        check_val("post_rst_idle_valid", pc_valid, 64'h0);
        check_val("post_rst_idle_pc",    pc_out,   64'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("restart_pc",    pc_out,     64'h0);
        check_val("restart_valid", pc_valid,   64'h1);
        check_val("restart_count", inst_count, 64'h0);

        // Stall on the edge that would reach the budget: no halt yet
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        check_val("pre_budget_pc",    pc_out,     64'd28);
        check_val("pre_budget_count", inst_count, 64'd7);
        stall = 1'b1;
        tick();
        check_val("stall_budget_halted", halted,     64'h0);
        check_val("stall_budget_count",  inst_count, 64'd7);
        check_val("stall_budget_valid",  pc_valid,   64'h1);
        stall = 1'b0;
        tick();
        check_val("budget_pc",     pc_out, 64'd32);
        check_val("budget_halted", halted, 64'h1);

`ifdef PC_ALIGN_CHECK_EN
        check_val("aligned_no_fault",      align_fault,      64'h0);
        check_val("wrap_aligned_no_fault", align_fault_wrap, 64'h0);
        start_mis = 1'b1;
        tick();
        start_mis = 1'b0;
        check_val("mis_start_pc",    pc_mis,          64'h2);
        check_val("mis_start_fault", align_fault_mis, 64'h0);
        tick();
        check_val("mis_pc",     pc_mis,          64'h6);
        check_val("mis_fault",  align_fault_mis, 64'h1);
        check_val("mis_halted", halted_mis,      64'h1);
        check_val("mis_count",  count_mis,       64'h1);
        check_val("mis_valid",  valid_mis,       64'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Drives the program counter into the instruction-memory/decode path of the single-cycle LEGv8 datapath.
- Replaces the bench-driven PC loop with an on-chip sequencer that produces the PC, selects the next PC (sequential or branch), honours stall, and halts after a fixed instruction budget.
- The datapath returns branch_taken (Branch & Zero, or unconditional B) and the sign-extended word offset.

Parameters:
- ADDR_W, 64, PC and offset width.
- RESET_PC, 0, PC loaded on reset and on start.
- MAX_INSTR, 8, number of instructions issued before HALT (>=1).
- CNT_W, 16, width of inst_count.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin fetching from RESET_PC (sampled in IDLE only).
- stall  in  1  hold PC and count this cycle.
- branch_taken  in  1  select branch target for the next PC.
- branch_offset  in  ADDR_W  signed word offset (already sign-extended).
- pc_out  out  ADDR_W  registered current PC.
- adder_out  out  ADDR_W  combinational pc_out + 4.
- pc_valid  out  1  pc_out holds an instruction to execute.
- inst_count  out  CNT_W  instructions retired since start.
- halted  out  1  sticky; budget exhausted (or fault, see the optional feature).

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high.
  - Reset values: pc_out=RESET_PC, pc_valid=0, inst_count=0, halted=0, state=IDLE.
  - Reset asserted mid-run aborts immediately with no drain; start is required again after release.
- IDLE:
  - pc_valid=0.
  - start=1 -> RUN next edge; pc_out=RESET_PC, pc_valid=1 the same edge.
- RUN:
  - Edge with stall=0 retires the current instruction and increments inst_count.
  - Next PC when branch_taken=1: pc_out + (branch_offset << 2).
  - Next PC otherwise: pc_out + 4, identical to adder_out.
  - Edge with stall=1 holds pc_out and inst_count; branch_taken is ignored (the datapath holds it).
- HALT:
  - Entered on the retiring edge where inst_count becomes MAX_INSTR.
  - pc_valid=0, halted=1, pc_out frozen at the last computed next-PC.
  - Sticky until reset; start is ignored.
- Latency: one cycle from a retiring edge to the new pc_out.
- start while in RUN: ignored (no restart).
- Arithmetic:
  - All PC math is modulo 2^ADDR_W; wrap past all-ones is legal and silent.
  - Negative offsets are two's complement; offset << 2 discards the top two bits.
- inst_count saturates at 2^CNT_W-1. This is unreachable if MAX_INSTR fits in CNT_W; MAX_INSTR must fit, enforced by an elaboration-time check.
- Simultaneous stall=1 and budget reached: no retire, so no HALT that cycle.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output align_fault (1 bit, reset 0).
  - If a computed next PC has bits[1:0] != 0, the sequencer enters HALT on that edge.
  - In that case halted=1, align_fault=1, and pc_out captures the misaligned address for debug.
  - inst_count still increments for the faulting retire.
- Undefined:
  - No port and no check.
  - Misaligned targets are passed through unchanged.

Decomposition:
- Shared package holds:
  - State enum: IDLE=2'd0, RUN=2'd1, HALT=2'd2.
  - Constant INSTR_BYTES=4.
  - Constant WORD_SHIFT=2.
- Sub-module: pc_next_mux, combinational.
  - Inputs: pc, branch_taken, offset.
  - Outputs: adder_out and next_pc.
  - Reused by the later pipelined fetch stage.

Test Plan:
- Reset, start pulse, no stall/branch, MAX_INSTR=8 -> pc_out 0,4,...,28 on successive edges; after the 8th retire halted=1, pc_valid=0, inst_count=8, pc_out=32.
- In RUN at pc=8, branch_taken=1, offset=+3 -> next pc_out=20; offset=-2 from pc=20 -> pc_out=12.
- stall=1 for 3 cycles at pc=12 with branch_taken=1 -> pc_out stays 12, inst_count unchanged; on release with branch_taken=0 -> pc_out=16.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, no branch -> second pc_out=0 (wrap), no flag.
- Assert reset mid-run at pc=16 between edges -> outputs return to reset values immediately (asynchronously); start needed to resume at RESET_PC.
- With PC_ALIGN_CHECK_EN and a 4-byte-aligned RESET_PC, any sequence of retires -> align_fault stays 0. Direct check: force a retire at pc=4 with branch_taken=1, offset=0 -> next pc_out=4, no fault. Faulting path: drive RESET_PC=2 -> after start, the first retire computes 6 -> align_fault=1, halted=1, pc_out=6.
